// File: rtl/frv_dmem_arbiter_if.sv
// Single data-memory bus: the master issues requests, the slave answers with stall/error/rdata.
interface frv_dmem_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic          cen;
  logic          wen;
  logic [SW-1:0] strb;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          stall;
  logic          error;
  logic [DW-1:0] rdata;

  modport master (output cen, wen, strb, addr, wdata, input  stall, error, rdata);
  modport slave  (input  cen, wen, strb, addr, wdata, output stall, error, rdata);
endinterface

// File: rtl/frv_dmem_arbiter.sv
// Two-master arbiter for the core data memory port: fixed priority to port 0,
// grant held across stalls, starvation counter promotes port 1.
module frv_dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CW           = 4
) (
  input  logic                      g_clk,
  input  logic                      g_reset,
  frv_dmem_arbiter_if.slave         p0,
  frv_dmem_arbiter_if.slave         p1,
  frv_dmem_arbiter_if.master        dmem,
  output logic [1:0]                arb_owner
);

  // Encoding doubles as the {locked, owner} trace value.
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] LOCK0 = 2'b10;
  localparam logic [1:0] LOCK1 = 2'b11;

  localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CTR_MAX = {CW{1'b1}};

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] starve_ctr_q, starve_ctr_d;
  logic          gnt0, gnt1;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q      <= IDLE;
      starve_ctr_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_ctr_q <= starve_ctr_d;
    end
  end

  // Grant selection; a locked port keeps the grant only while it still requests.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = IDLE;
    if (!g_reset) begin
      case (state_q)
        LOCK0:   gnt0 = p0.cen;
        LOCK1:   gnt1 = p1.cen;
        default: begin
          gnt1 = p1.cen && (!p0.cen || (starve_ctr_q >= LIMIT));
          gnt0 = p0.cen && !gnt1;
        end
      endcase
    end
    if (gnt0 && dmem.stall) begin
      state_d = LOCK0;
    end else if (gnt1 && dmem.stall) begin
      state_d = LOCK1;
    end
  end

  always_comb begin
    starve_ctr_d = '0;
    if (p1.cen && !gnt1) begin
      starve_ctr_d = (starve_ctr_q == CTR_MAX) ? CTR_MAX : starve_ctr_q + CW'(1);
    end
  end

  // Request mux towards memory.
  always_comb begin
    dmem.cen   = 1'b0;
    dmem.wen   = 1'b0;
    dmem.strb  = '0;
    dmem.addr  = '0;
    dmem.wdata = '0;
    if (gnt0) begin
      dmem.cen   = 1'b1;
      dmem.wen   = p0.wen;
      dmem.strb  = p0.strb;
      dmem.addr  = p0.addr;
      dmem.wdata = p0.wdata;
    end else if (gnt1) begin
      dmem.cen   = 1'b1;
      dmem.wen   = p1.wen;
      dmem.strb  = p1.strb;
      dmem.addr  = p1.addr;
      dmem.wdata = p1.wdata;
    end
  end

  // Response demux; a waiting requester sees stall, everyone stalls in reset.
  always_comb begin
    p0.stall = gnt0 ? dmem.stall : (p0.cen || g_reset);
    p0.error = gnt0 && dmem.error;
    p0.rdata = gnt0 ? dmem.rdata : '0;
    p1.stall = gnt1 ? dmem.stall : (p1.cen || g_reset);
    p1.error = gnt1 && dmem.error;
    p1.rdata = gnt1 ? dmem.rdata : '0;
  end

  assign arb_owner = state_q;

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
// Randomised scoreboard bench for frv_dmem_arbiter: a transaction-level reference
// model predicts every cycle's outputs, a negedge monitor compares them.
module tb_frv_dmem_arbiter;
  localparam int unsigned STARVE_LIMIT = 8;
  localparam int unsigned CW           = 4;
  localparam int          WAIT_MAX     = (1 << CW) - 1;

  typedef struct packed {
    logic        cen;
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        dcen;
    logic        dwen;
    logic [3:0]  dstrb;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        stall0;
    logic        error0;
    logic [31:0] rdata0;
    logic        stall1;
    logic        error1;
    logic [31:0] rdata1;
    logic [1:0]  owner;
  } exp_t;

  logic       clk;
  logic       g_reset;
  logic [1:0] arb_owner;

  frv_dmem_arbiter_if p0_if ();
  frv_dmem_arbiter_if p1_if ();
  frv_dmem_arbiter_if dmem_if ();

  frv_dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CW(CW)) dut (
    .g_clk    (clk),
    .g_reset  (g_reset),
    .p0       (p0_if.slave),
    .p1       (p1_if.slave),
    .dmem     (dmem_if.master),
    .arb_owner(arb_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference model: who holds the bus across a stall, and how long port 1 has waited.
  int   lock_own = -1;
  int   p1_wait  = 0;
  req_t prev0, prev1;
  logic last_stall0, last_stall1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endfunction

  function automatic req_t mk(input logic cen, input logic wen, input logic [3:0] strb,
                              input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.cen = cen; r.wen = wen; r.strb = strb; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic req_t gen(input req_t prev, input logic hold);
    req_t r;
    if (hold) begin
      r     = prev;
      r.cen = ($urandom_range(99) < 90);
    end else begin
      r = mk($urandom_range(99) < 60, 1'($urandom_range(1)), 4'($urandom),
             $urandom, $urandom);
    end
    return r;
  endfunction

  task automatic issue(input logic rst, input req_t r0, input req_t r1,
                       input logic st, input logic er, input logic [31:0] rd);
    exp_t e;
    int   g;
    @(posedge clk);
    #1;
    cyc++;
    g_reset       = rst;
    p0_if.cen     = r0.cen;  p0_if.wen  = r0.wen;  p0_if.strb = r0.strb;
    p0_if.addr    = r0.addr; p0_if.wdata = r0.wdata;
    p1_if.cen     = r1.cen;  p1_if.wen  = r1.wen;  p1_if.strb = r1.strb;
    p1_if.addr    = r1.addr; p1_if.wdata = r1.wdata;
    dmem_if.stall = st;
    dmem_if.error = er;
    dmem_if.rdata = rd;

    if (rst)                 g = -1;
    else if (lock_own == 0)  g = r0.cen ? 0 : -1;
    else if (lock_own == 1)  g = r1.cen ? 1 : -1;
    else if (r1.cen && (!r0.cen || p1_wait >= int'(STARVE_LIMIT))) g = 1;
    else if (r0.cen)         g = 0;
    else                     g = -1;

    e = '0;
    e.owner = (lock_own < 0) ? 2'b00 : {1'b1, 1'(lock_own == 1)};
    if (g == 0) begin
      e.dcen = 1'b1; e.dwen = r0.wen; e.dstrb = r0.strb; e.daddr = r0.addr; e.dwdata = r0.wdata;
    end else if (g == 1) begin
      e.dcen = 1'b1; e.dwen = r1.wen; e.dstrb = r1.strb; e.daddr = r1.addr; e.dwdata = r1.wdata;
    end
    e.stall0 = (g == 0) ? st : (rst | r0.cen);
    e.error0 = (g == 0) && er;
    e.rdata0 = (g == 0) ? rd : 32'h0;
    e.stall1 = (g == 1) ? st : (rst | r1.cen);
    e.error1 = (g == 1) && er;
    e.rdata1 = (g == 1) ? rd : 32'h0;
    exp_q.push_back(e);

    prev0 = r0; prev1 = r1;
    last_stall0 = e.stall0 && !rst;
    last_stall1 = e.stall1 && !rst;
    if (rst) begin
      lock_own = -1;
      p1_wait  = 0;
    end else begin
      lock_own = (g >= 0 && st) ? g : -1;
      p1_wait  = (r1.cen && g != 1) ? ((p1_wait < WAIT_MAX) ? p1_wait + 1 : WAIT_MAX) : 0;
    end
  endtask

  // Monitor: the arbiter presents a response every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dmem_cen",   32'(dmem_if.cen),   32'(e.dcen));
        chk("dmem_wen",   32'(dmem_if.wen),   32'(e.dwen));
        chk("dmem_strb",  32'(dmem_if.strb),  32'(e.dstrb));
        chk("dmem_addr",  dmem_if.addr,       e.daddr);
        chk("dmem_wdata", dmem_if.wdata,      e.dwdata);
        chk("p0_stall",   32'(p0_if.stall),   32'(e.stall0));
        chk("p0_error",   32'(p0_if.error),   32'(e.error0));
        chk("p0_rdata",   p0_if.rdata,        e.rdata0);
        chk("p1_stall",   32'(p1_if.stall),   32'(e.stall1));
        chk("p1_error",   32'(p1_if.error),   32'(e.error1));
        chk("p1_rdata",   p1_if.rdata,        e.rdata1);
        chk("arb_owner",  32'(arb_owner),     32'(e.owner));
      end
    end
  end

  initial begin
    req_t idle, w0, rd0, r1, a, b;
    idle = '0;
    g_reset = 1'b1;
    p0_if.cen = 1'b0; p0_if.wen = 1'b0; p0_if.strb = '0; p0_if.addr = '0; p0_if.wdata = '0;
    p1_if.cen = 1'b0; p1_if.wen = 1'b0; p1_if.strb = '0; p1_if.addr = '0; p1_if.wdata = '0;
    dmem_if.stall = 1'b0; dmem_if.error = 1'b0; dmem_if.rdata = '0;
    repeat (2) @(posedge clk);

    w0  = mk(1'b1, 1'b1, 4'hF, 32'h0000_0200, 32'hDEAD_BEEF);
    rd0 = mk(1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0);
    r1  = mk(1'b1, 1'b0, 4'h0, 32'h0000_0300, 32'h0);

    // Reset with both ports requesting: no grant, both stalled.
    issue(1'b1, rd0, r1, 1'b0, 1'b1, 32'h1111_1111);
    // Single-cycle read on port 0.
    issue(1'b0, rd0, idle, 1'b0, 1'b0, 32'hCAFE_0001);
    // Port 0 write stalled three cycles while port 1 waits.
    issue(1'b0, w0, idle, 1'b1, 1'b0, $urandom);
    issue(1'b0, w0, r1,   1'b1, 1'b0, $urandom);
    issue(1'b0, w0, r1,   1'b1, 1'b0, $urandom);
    issue(1'b0, w0, r1,   1'b0, 1'b0, $urandom);
    issue(1'b0, idle, r1, 1'b0, 1'b0, 32'h0BAD_F00D);
    // Continuous contention: port 1 wins once it has waited the limit.
    for (int i = 0; i < 11; i++) begin
      a = mk(1'b1, 1'b0, 4'h0, 32'h400 + 32'(4 * i), 32'h0);
      b = mk(1'b1, 1'b0, 4'h0, 32'h500, 32'h0);
      issue(1'b0, a, b, 1'b0, 1'b0, $urandom);
    end
    // Port 1 locks, then abandons; pending port 0 follows.
    issue(1'b0, idle, r1, 1'b1, 1'b0, $urandom);
    issue(1'b0, rd0, idle, 1'b1, 1'b0, $urandom);
    issue(1'b0, rd0, idle, 1'b0, 1'b0, $urandom);
    // Error on a port 1 completion.
    issue(1'b0, idle, r1, 1'b0, 1'b1, 32'h5555_AAAA);
    // Reset while port 0 holds the lock.
    issue(1'b0, w0, idle, 1'b1, 1'b0, $urandom);
    issue(1'b1, w0, r1,   1'b1, 1'b0, $urandom);
    issue(1'b0, idle, idle, 1'b0, 1'b0, $urandom);

    for (int c = 0; c < 3000; c++) begin
      a = gen(prev0, prev0.cen && last_stall0);
      b = gen(prev1, prev1.cen && last_stall1);
      issue($urandom_range(99) < 2, a, b, $urandom_range(99) < 40,
            $urandom_range(99) < 20, $urandom);
    end

    repeat (2) @(negedge clk);
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
